// File: rtl/seat_alloc_scheduler.sv
// Seat-allocation scheduler: round-robin arbitration of entry/exit gate
// requests, admission checks (person type, capacity, window, alarm), and
// commit of per-event present counts and the total admitted count.
//
// Ports:
//   Clock              system clock, all state on posedge
//   Clear              synchronous active-low reset
//   Start              one-cycle pulse, opens/reloads the admission window
//   Alarm              emergency alarm level
//   Req/Dir            per-gate request and direction (1 = entry, 0 = exit)
//   PType/Event        per-gate person type and event select, 2 bits each
//   Grant              one-hot completion pulse for the served gate
//   Accept/Reject      outcome pulses, coincident with Grant
//   RejCode            reject reason, valid while Reject = 1
//   PC_out             per-event present counts, event e at [e*CAP_W +: CAP_W]
//   TC_out/TC_Ovf      total admitted count and sticky saturation flag
//   Full               per-event PC == MAX_CAP
//   WindowOpen         admission window active
//   EA_LED             Alarm delayed by one cycle
//   Busy               transaction in progress (EVAL or RESP)
module seat_alloc_scheduler #(
  parameter int unsigned NUM_GATES = 4,
  parameter int unsigned CAP_W     = 4,
  parameter int unsigned MAX_CAP   = 15,
  parameter int unsigned TC_W      = 6,
  parameter int unsigned WINDOW    = 15
) (
  input  logic                   Clock,
  input  logic                   Clear,
  input  logic                   Start,
  input  logic                   Alarm,
  input  logic [NUM_GATES-1:0]   Req,
  input  logic [NUM_GATES-1:0]   Dir,
  input  logic [2*NUM_GATES-1:0] PType,
  input  logic [2*NUM_GATES-1:0] Event,
  output logic [NUM_GATES-1:0]   Grant,
  output logic                   Accept,
  output logic                   Reject,
  output logic [1:0]             RejCode,
  output logic [4*CAP_W-1:0]     PC_out,
  output logic [TC_W-1:0]        TC_out,
  output logic                   TC_Ovf,
  output logic [3:0]             Full,
  output logic                   WindowOpen,
  output logic                   EA_LED,
  output logic                   Busy
);

  localparam int unsigned GW = (NUM_GATES > 1) ? $clog2(NUM_GATES) : 1;
  localparam int unsigned TW = $clog2(WINDOW + 1);
  localparam logic [CAP_W-1:0] CAP_MAX = CAP_W'(MAX_CAP);
  localparam logic [TC_W-1:0]  TC_SAT  = {TC_W{1'b1}};

  localparam logic [1:0] RC_FULL_EMPTY = 2'b00;
  localparam logic [1:0] RC_CLOSED     = 2'b01;
  localparam logic [1:0] RC_ALARM      = 2'b10;
  localparam logic [1:0] RC_INVALID    = 2'b11;

  typedef enum logic [1:0] {IDLE, EVAL, RESP} state_t;

  state_t                  state_q;
  logic [GW-1:0]           rr_q, win_q;
  logic                    dir_q;
  logic [1:0]              ptype_q, ev_q;
  logic [TW-1:0]           timer_q, timer_d;
  logic                    win_open_q;
  logic [3:0][CAP_W-1:0]   pc_q, pc_d;
  logic [TC_W-1:0]         tc_q, tc_d;
  logic                    ovf_q, ovf_d;
  logic [3:0]              full_q, full_d;
  logic [NUM_GATES-1:0]    grant_q;
  logic                    acc_q, rej_q, ea_q, busy_q;
  logic [1:0]              code_q;

  // Round-robin pick: rotate requests so the pointer gate sits at bit 0
  logic [2*NUM_GATES-1:0]  req_dbl;
  logic [GW-1:0]           pick_c;
  logic                    found;
  logic                    dir_sel;
  logic [1:0]              ptype_sel, ev_sel;

  always_comb begin
    req_dbl   = {Req, Req} >> rr_q;
    found     = 1'b0;
    pick_c    = rr_q;
    dir_sel   = 1'b0;
    ptype_sel = 2'b00;
    ev_sel    = 2'b00;
    for (int i = 0; i < int'(NUM_GATES); i++) begin
      if (!found && req_dbl[i]) begin
        found  = 1'b1;
        pick_c = GW'((int'(rr_q) + i) % int'(NUM_GATES));
      end
    end
    for (int g = 0; g < int'(NUM_GATES); g++) begin
      if (GW'(g) == pick_c) begin
        dir_sel   = Dir[g];
        ptype_sel = PType[2*g +: 2];
        ev_sel    = Event[2*g +: 2];
      end
    end
  end

  // Admission decision on the latched request
  logic             is_att, is_staff, dec_acc;
  logic [1:0]       dec_code;
  logic [CAP_W-1:0] pc_sel;

  always_comb begin
    is_att   = (ptype_q == 2'b00);
    is_staff = (ptype_q == 2'b11);
    pc_sel   = pc_q[ev_q];
    dec_acc  = 1'b0;
    dec_code = RC_FULL_EMPTY;
    if (!(is_att || is_staff)) begin
      dec_code = RC_INVALID;
    end else if (dir_q) begin
      if (Alarm)                          dec_code = RC_ALARM;
      else if (!win_open_q)               dec_code = RC_CLOSED;
      // Staff do not occupy seats, so only attendees can hit FULL
      else if (is_att && pc_sel == CAP_MAX) dec_code = RC_FULL_EMPTY;
      else                                dec_acc  = 1'b1;
    end else begin
      if (is_att && pc_sel == '0) dec_code = RC_FULL_EMPTY;
      else                        dec_acc  = 1'b1;
    end
  end

  // Counter and window next-state; commits only on the EVAL exit edge
  always_comb begin
    pc_d  = pc_q;
    tc_d  = tc_q;
    ovf_d = ovf_q;
    if (state_q == EVAL && dec_acc) begin
      if (is_att) pc_d[ev_q] = dir_q ? pc_sel + CAP_W'(1) : pc_sel - CAP_W'(1);
      if (dir_q) begin
        if (tc_q == TC_SAT) ovf_d = 1'b1;
        else                tc_d  = tc_q + TC_W'(1);
      end
    end
    for (int e = 0; e < 4; e++) full_d[e] = (pc_d[e] == CAP_MAX);
    // Start wins over the final decrement
    if (Start)              timer_d = TW'(WINDOW);
    else if (timer_q != '0) timer_d = timer_q - TW'(1);
    else                    timer_d = timer_q;
  end

  // FSM, counters and registered outputs
  always_ff @(posedge Clock) begin
    if (!Clear) begin
      state_q    <= IDLE;
      rr_q       <= '0;
      win_q      <= '0;
      dir_q      <= 1'b0;
      ptype_q    <= 2'b00;
      ev_q       <= 2'b00;
      timer_q    <= '0;
      win_open_q <= 1'b0;
      pc_q       <= '0;
      tc_q       <= '0;
      ovf_q      <= 1'b0;
      full_q     <= '0;
      grant_q    <= '0;
      acc_q      <= 1'b0;
      rej_q      <= 1'b0;
      code_q     <= 2'b00;
      ea_q       <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      ea_q       <= Alarm;
      timer_q    <= timer_d;
      win_open_q <= (timer_d != '0);
      pc_q       <= pc_d;
      tc_q       <= tc_d;
      ovf_q      <= ovf_d;
      full_q     <= full_d;
      grant_q    <= '0;
      acc_q      <= 1'b0;
      rej_q      <= 1'b0;
      code_q     <= 2'b00;
      case (state_q)
        IDLE: begin
          if (|Req) begin
            win_q   <= pick_c;
            dir_q   <= dir_sel;
            ptype_q <= ptype_sel;
            ev_q    <= ev_sel;
            busy_q  <= 1'b1;
            state_q <= EVAL;
          end
        end
        EVAL: begin
          grant_q <= NUM_GATES'(1) << win_q;
          acc_q   <= dec_acc;
          rej_q   <= !dec_acc;
          code_q  <= dec_acc ? 2'b00 : dec_code;
          state_q <= RESP;
        end
        RESP: begin
          rr_q    <= (win_q == GW'(NUM_GATES - 1)) ? '0 : win_q + GW'(1);
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign Grant      = grant_q;
  assign Accept     = acc_q;
  assign Reject     = rej_q;
  assign RejCode    = code_q;
  assign PC_out     = pc_q;
  assign TC_out     = tc_q;
  assign TC_Ovf     = ovf_q;
  assign Full       = full_q;
  assign WindowOpen = win_open_q;
  assign EA_LED     = ea_q;
  assign Busy       = busy_q;

endmodule

// File: tb/tb_seat_alloc_scheduler.sv
// Testbench for seat_alloc_scheduler: directed vector table plus hand-written
// sequences for arbitration order, window timing, alarm LED, mid-transaction
// reset and total-count saturation.
module tb_seat_alloc_scheduler;

  logic        Clock, Clear, Start, Alarm;
  logic [3:0]  Req, Dir;
  logic [7:0]  PType, Event;
  logic [3:0]  Grant;
  logic        Accept, Reject;
  logic [1:0]  RejCode;
  logic [15:0] PC_out;
  logic [5:0]  TC_out;
  logic        TC_Ovf;
  logic [3:0]  Full;
  logic        WindowOpen, EA_LED, Busy;

  seat_alloc_scheduler #(
    .NUM_GATES(4), .CAP_W(4), .MAX_CAP(15), .TC_W(6), .WINDOW(15)
  ) dut (
    .Clock(Clock), .Clear(Clear), .Start(Start), .Alarm(Alarm),
    .Req(Req), .Dir(Dir), .PType(PType), .Event(Event),
    .Grant(Grant), .Accept(Accept), .Reject(Reject), .RejCode(RejCode),
    .PC_out(PC_out), .TC_out(TC_out), .TC_Ovf(TC_Ovf), .Full(Full),
    .WindowOpen(WindowOpen), .EA_LED(EA_LED), .Busy(Busy)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  typedef struct {
    logic [3:0]  gr;
    logic        acc;
    logic        rej;
    logic [1:0]  code;
    int          lat;
    int          busy_n;
    logic [15:0] pc;
    logic [5:0]  tc;
    logic [3:0]  full;
    logic        ovf;
  } resp_t;

  typedef struct {
    int         g;
    bit         start;
    bit         alarm;
    bit         dir;
    bit [1:0]   pt;
    bit [1:0]   ev;
    bit         acc;
    bit [1:0]   code;
    int         pc;
    int         tc;
  } vec_t;

  // All tasks start and end just after a negedge
  task automatic clear_dut();
    Clear = 1'b0;
    Req   = '0;
    @(negedge Clock);
    Clear = 1'b1;
  endtask

  task automatic pulse_start();
    Start = 1'b1;
    @(negedge Clock);
    Start = 1'b0;
  endtask

  // Single request; returns the outputs seen in the Grant cycle, then steps
  // one more cycle so the DUT is back in IDLE with Req low.
  task automatic xact(input int g, input logic d, input logic [1:0] pt,
                      input logic [1:0] ev, output resp_t r);
    Req[g]           = 1'b1;
    Dir[g]           = d;
    PType[2*g +: 2]  = pt;
    Event[2*g +: 2]  = ev;
    r = '{default: '0};
    while (r.lat < 40) begin
      @(negedge Clock);
      r.lat++;
      if (Busy) r.busy_n++;
      if (Grant != 4'b0000) break;
    end
    if (Grant == 4'b0000) chk("grant_timeout", 32'(Grant), 32'(1 << g));
    r.gr   = Grant;
    r.acc  = Accept;
    r.rej  = Reject;
    r.code = RejCode;
    r.pc   = PC_out;
    r.tc   = TC_out;
    r.full = Full;
    r.ovf  = TC_Ovf;
    Req[g] = 1'b0;
    @(negedge Clock);
  endtask

  vec_t  vt[13];
  resp_t r;
  int    n_acc;

  initial begin
    Clear = 1'b0; Start = 1'b0; Alarm = 1'b0;
    Req = '0; Dir = '0; PType = '0; Event = '0;

    vt[0]  = '{1, 1'b0, 1'b0, 1'b1, 2'b00, 2'd0, 1'b0, 2'b01, 0, 0};
    vt[1]  = '{0, 1'b0, 1'b1, 1'b1, 2'b00, 2'd0, 1'b0, 2'b10, 0, 0};
    vt[2]  = '{1, 1'b0, 1'b0, 1'b1, 2'b10, 2'd0, 1'b0, 2'b11, 0, 0};
    vt[3]  = '{2, 1'b0, 1'b0, 1'b0, 2'b00, 2'd3, 1'b0, 2'b00, 0, 0};
    vt[4]  = '{3, 1'b1, 1'b0, 1'b1, 2'b11, 2'd0, 1'b1, 2'b00, 0, 1};
    vt[5]  = '{0, 1'b1, 1'b0, 1'b1, 2'b00, 2'd0, 1'b1, 2'b00, 1, 2};
    vt[6]  = '{0, 1'b1, 1'b0, 1'b1, 2'b00, 2'd0, 1'b1, 2'b00, 2, 3};
    vt[7]  = '{0, 1'b1, 1'b0, 1'b1, 2'b00, 2'd0, 1'b1, 2'b00, 3, 4};
    vt[8]  = '{1, 1'b1, 1'b1, 1'b1, 2'b00, 2'd0, 1'b0, 2'b10, 3, 4};
    vt[9]  = '{2, 1'b0, 1'b1, 1'b0, 2'b00, 2'd0, 1'b1, 2'b00, 2, 4};
    vt[10] = '{0, 1'b0, 1'b1, 1'b1, 2'b01, 2'd0, 1'b0, 2'b11, 2, 4};
    vt[11] = '{3, 1'b1, 1'b0, 1'b0, 2'b11, 2'd0, 1'b1, 2'b00, 2, 4};
    vt[12] = '{1, 1'b0, 1'b0, 1'b0, 2'b00, 2'd0, 1'b1, 2'b00, 1, 4};

    // Reset state
    @(negedge Clock);
    chk("rst_grant", 32'(Grant), 32'd0);
    chk("rst_accept_reject_code", 32'({Accept, Reject, RejCode}), 32'd0);
    chk("rst_pc", 32'(PC_out), 32'd0);
    chk("rst_tc_ovf", 32'({TC_Ovf, TC_out}), 32'd0);
    chk("rst_full_win_ea_busy", 32'({Full, WindowOpen, EA_LED, Busy}), 32'd0);
    Clear = 1'b1;

    // Single attendee entry, latency and Busy
    pulse_start();
    xact(0, 1'b1, 2'b00, 2'd2, r);
    chk("t1_grant", 32'(r.gr), 32'b0001);
    chk("t1_accept", 32'({r.acc, r.rej}), 32'b10);
    chk("t1_latency", 32'(r.lat), 32'd2);
    chk("t1_busy_cycles", 32'(r.busy_n), 32'd2);
    chk("t1_pc2", 32'(r.pc[8 +: 4]), 32'd1);
    chk("t1_tc", 32'(r.tc), 32'd1);
    chk("t1_busy_idle", 32'(Busy), 32'd0);

    // Window timing and reload on the final decrement
    pulse_start();
    repeat (14) @(negedge Clock);
    chk("win_last_open", 32'(WindowOpen), 32'd1);
    Start = 1'b1;
    @(negedge Clock);
    Start = 1'b0;
    chk("win_reload_at_end", 32'(WindowOpen), 32'd1);
    repeat (14) @(negedge Clock);
    chk("win_reload_last", 32'(WindowOpen), 32'd1);
    @(negedge Clock);
    chk("win_closed", 32'(WindowOpen), 32'd0);

    // EA_LED follows Alarm by one cycle
    Alarm = 1'b1;
    chk("ea_before", 32'(EA_LED), 32'd0);
    @(negedge Clock);
    chk("ea_set", 32'(EA_LED), 32'd1);
    Alarm = 1'b0;
    @(negedge Clock);
    chk("ea_clr", 32'(EA_LED), 32'd0);

    // Round-robin among gates 0, 1, 3; gate 0 re-requests after gate 3
    clear_dut();
    begin
      logic [3:0] exp_gr [4];
      int         exp_t  [4];
      int         n, t;
      exp_gr = '{4'b0001, 4'b0010, 4'b1000, 4'b0001};
      exp_t  = '{2, 5, 8, 11};
      Dir   = 4'b0000;
      PType = 8'hFF;
      Req   = 4'b1011;
      n = 0;
      t = 0;
      while (n < 4 && t < 60) begin
        @(negedge Clock);
        t++;
        if (Grant != 4'b0000) begin
          chk($sformatf("rr_grant%0d", n), 32'(Grant), 32'(exp_gr[n]));
          chk($sformatf("rr_time%0d", n), 32'(t), 32'(exp_t[n]));
          chk($sformatf("rr_accept%0d", n), 32'(Accept), 32'd1);
          Req = Req & ~Grant;
          if (n == 2) Req[0] = 1'b1;
          n++;
        end
      end
      if (n < 4) chk("rr_timeout", 32'(n), 32'd4);
      Req = '0;
      @(negedge Clock);
      PType = '0;
    end

    // Reject priorities and alarm/exit behaviour from the vector table
    clear_dut();
    for (int i = 0; i < 13; i++) begin
      Alarm = vt[i].alarm;
      if (vt[i].start) pulse_start();
      xact(vt[i].g, vt[i].dir, vt[i].pt, vt[i].ev, r);
      chk($sformatf("v%0d_grant", i), 32'(r.gr), 32'(1 << vt[i].g));
      chk($sformatf("v%0d_accept", i), 32'(r.acc), 32'(vt[i].acc));
      chk($sformatf("v%0d_reject", i), 32'(r.rej), 32'(!vt[i].acc));
      chk($sformatf("v%0d_code", i), 32'(r.code), 32'(vt[i].code));
      chk($sformatf("v%0d_pc", i), 32'(r.pc[vt[i].ev*4 +: 4]), 32'(vt[i].pc));
      chk($sformatf("v%0d_tc", i), 32'(r.tc), 32'(vt[i].tc));
    end
    Alarm = 1'b0;

    // Fill event 1 to capacity, overfill, then one exit
    clear_dut();
    for (int i = 0; i < 15; i++) begin
      pulse_start();
      xact(2, 1'b1, 2'b00, 2'd1, r);
      chk($sformatf("fill%0d_accept", i), 32'(r.acc), 32'd1);
      chk($sformatf("fill%0d_pc1", i), 32'(r.pc[4 +: 4]), 32'(i + 1));
    end
    chk("fill_full", 32'(r.full), 32'b0010);
    pulse_start();
    xact(2, 1'b1, 2'b00, 2'd1, r);
    chk("over_reject", 32'({r.acc, r.rej}), 32'b01);
    chk("over_code", 32'(r.code), 32'b00);
    chk("over_pc1", 32'(r.pc[4 +: 4]), 32'd15);
    xact(1, 1'b0, 2'b00, 2'd1, r);
    chk("exit_accept", 32'(r.acc), 32'd1);
    chk("exit_pc1", 32'(r.pc[4 +: 4]), 32'd14);
    chk("exit_full", 32'(r.full), 32'b0000);
    chk("fill_tc", 32'(r.tc), 32'd15);

    // Reset during EVAL aborts the transaction
    pulse_start();
    Req[0]          = 1'b1;
    Dir[0]          = 1'b1;
    PType[1:0]      = 2'b00;
    Event[1:0]      = 2'd1;
    @(negedge Clock);
    chk("abort_busy_eval", 32'(Busy), 32'd1);
    Clear = 1'b0;
    Req   = '0;
    @(negedge Clock);
    chk("abort_grant", 32'(Grant), 32'd0);
    chk("abort_counts", 32'({TC_out, PC_out}), 32'd0);
    chk("abort_win_busy", 32'({WindowOpen, Busy}), 32'd0);
    Clear = 1'b1;
    begin
      logic [3:0] seen;
      seen = '0;
      repeat (3) begin
        @(negedge Clock);
        seen = seen | Grant;
      end
      chk("abort_no_late_grant", 32'(seen), 32'd0);
    end

    // Total-count saturation
    n_acc = 0;
    for (int i = 0; i < 63; i++) begin
      pulse_start();
      xact(3, 1'b1, 2'b11, 2'd0, r);
      if (r.acc) n_acc++;
    end
    chk("sat_accepts", 32'(n_acc), 32'd63);
    chk("sat_tc", 32'(r.tc), 32'd63);
    chk("sat_ovf_pre", 32'(r.ovf), 32'd0);
    pulse_start();
    xact(3, 1'b1, 2'b11, 2'd0, r);
    chk("sat_accept", 32'(r.acc), 32'd1);
    chk("sat_tc_hold", 32'(r.tc), 32'd63);
    chk("sat_ovf_set", 32'(r.ovf), 32'd1);
    pulse_start();
    xact(0, 1'b1, 2'b00, 2'd0, r);
    chk("sat_att_accept", 32'(r.acc), 32'd1);
    chk("sat_att_pc0", 32'(r.pc[3:0]), 32'd1);
    chk("sat_ovf_sticky", 32'({r.ovf, r.tc}), 32'({1'b1, 6'd63}));
    clear_dut();
    chk("sat_ovf_clear", 32'(TC_Ovf), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
